// File: rtl/rice_bit_encoder_if.sv
// Handshake/bus bundle for the serial Rice encoder.
// The iStall wire exists only when RICE_STALL_EN is defined.
interface rice_bit_encoder_if #(
   parameter int DATA_WIDTH  = 16,
   parameter int PARAM_WIDTH = 4
);
   logic                   iValid;
   logic                   oReady;
   logic [DATA_WIDTH-1:0]  iData;
   logic [PARAM_WIDTH-1:0] iRiceParam;
   logic                   oData;
   logic                   oValid;
   logic                   oDone;
`ifdef RICE_STALL_EN
   logic                   iStall;
`endif

   modport master (
      output iValid, iData, iRiceParam,
`ifdef RICE_STALL_EN
      output iStall,
`endif
      input  oReady, oData, oValid, oDone
   );

   modport slave (
      input  iValid, iData, iRiceParam,
`ifdef RICE_STALL_EN
      input  iStall,
`endif
      output oReady, oData, oValid, oDone
   );
endinterface

// File: rtl/rice_bit_encoder.sv
// Serial Rice encoder: zig-zag maps a signed residual and emits unary q, a 0, then k bits.
// Optional output stall is enabled by defining RICE_STALL_EN.
module rice_bit_encoder #(
   parameter int DATA_WIDTH  = 16,
   parameter int PARAM_WIDTH = 4,
   parameter int CNT_WIDTH   = 16
) (
   input  logic       iClock,
   input  logic       iReset,
   rice_bit_encoder_if.slave io,
   output logic [1:0] o_dbg_state
);
   localparam logic [PARAM_WIDTH-1:0] K_MAX = PARAM_WIDTH'(14);
   localparam int SW = $clog2(DATA_WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_UNARY  = 2'd1,
      S_STOP   = 2'd2,
      S_BINARY = 2'd3
   } state_t;

   state_t                 r_state;
   logic [CNT_WIDTH-1:0]   r_cnt;
   logic [PARAM_WIDTH-1:0] r_k;
   logic [DATA_WIDTH-1:0]  r_sh;
   logic                   r_data;
   logic                   r_valid;
   logic                   r_done;

   logic                   w_stall;
   logic                   w_ready;
   logic                   w_accept;
   logic [DATA_WIDTH-1:0]  w_u;
   logic [PARAM_WIDTH-1:0] w_k;
   logic [DATA_WIDTH-1:0]  w_q;
   logic [DATA_WIDTH-1:0]  w_sh;

`ifdef RICE_STALL_EN
   assign w_stall = io.iStall;
`else
   assign w_stall = 1'b0;
`endif

   // Handshake: a residual is taken on a rising edge where iValid && oReady. oReady is
   // high in IDLE or while the last bit of a codeword is shown, so codewords chain gaplessly.
   assign w_ready  = ((r_state == S_IDLE) || r_done) && !w_stall;
   assign w_accept = io.iValid && w_ready;

   assign w_u  = {io.iData[DATA_WIDTH-2:0], 1'b0} ^ {DATA_WIDTH{io.iData[DATA_WIDTH-1]}};
   assign w_k  = (io.iRiceParam > K_MAX) ? K_MAX : io.iRiceParam;
   assign w_q  = w_u >> w_k;
   // Remainder left-aligned so the binary phase always shifts out of the MSB.
   assign w_sh = (w_u & ~({DATA_WIDTH{1'b1}} << w_k)) << (SW'(DATA_WIDTH) - SW'(w_k));

   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_k     <= '0;
         r_sh    <= '0;
         r_data  <= 1'b0;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
      end else if (!w_stall) begin
         if (w_accept) begin
            r_k     <= w_k;
            r_sh    <= w_sh;
            r_valid <= 1'b1;
            if (w_q != '0) begin
               r_state <= S_UNARY;
               r_cnt   <= CNT_WIDTH'(w_q);
               r_data  <= 1'b1;
               r_done  <= 1'b0;
            end else begin
               r_state <= S_STOP;
               r_cnt   <= '0;
               r_data  <= 1'b0;
               r_done  <= (w_k == '0);
            end
         end else if (r_done || (r_state == S_IDLE)) begin
            r_state <= S_IDLE;
            r_data  <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
         end else begin
            case (r_state)
               S_UNARY: begin
                  if (r_cnt == CNT_WIDTH'(1)) begin
                     r_state <= S_STOP;
                     r_data  <= 1'b0;
                     r_done  <= (r_k == '0);
                  end else begin
                     r_cnt <= r_cnt - CNT_WIDTH'(1);
                  end
               end
               S_STOP: begin
                  r_state <= S_BINARY;
                  r_cnt   <= CNT_WIDTH'(r_k);
                  r_data  <= r_sh[DATA_WIDTH-1];
                  r_sh    <= r_sh << 1;
                  r_done  <= (r_k == PARAM_WIDTH'(1));
               end
               S_BINARY: begin
                  r_cnt  <= r_cnt - CNT_WIDTH'(1);
                  r_data <= r_sh[DATA_WIDTH-1];
                  r_sh   <= r_sh << 1;
                  r_done <= (r_cnt == CNT_WIDTH'(2));
               end
               default: begin
                  r_state <= S_IDLE;
                  r_data  <= 1'b0;
                  r_valid <= 1'b0;
                  r_done  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign io.oReady   = w_ready;
   assign io.oData    = r_data;
   assign io.oValid   = r_valid;
   assign io.oDone    = r_done;
   assign o_dbg_state = r_state;
endmodule
